seg_scan_driver: RTL and testbench

SEG_SCAN_DRIVER -- requirements
Module: seg_scan_driver

---
 rtl/seg_scan_driver_pkg.sv | 27 ++
 rtl/bcd_to_seg7.sv | 26 ++
 rtl/seg_scan_driver.sv | 111 +++++++++++
 tb/tb_seg_scan_driver.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/seg_scan_driver_pkg.sv
// rtl/seg_scan_driver_pkg.sv - shared display constants and types for the segment scan driver
package seg_scan_driver_pkg;

  localparam int DEF_CLK_HZ   = 50_000_000;
  localparam int DEF_SCAN_DIV = 50_000;
  localparam int DEF_GUARD    = 16;

  // Active-high patterns, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  typedef struct packed {
    logic [3:0][3:0] digit;
    logic            blank_lz;
    logic            blink_en;
  } shadow_t;

endpackage

// File: rtl/bcd_to_seg7.sv
// rtl/bcd_to_seg7.sv - combinational BCD to active-high 7-segment decode
module bcd_to_seg7
  import seg_scan_driver_pkg::*;
(
  input  logic [3:0] bcd_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_BLANK;
    case (bcd_i)
      4'd0: seg_o = SEG_0;
      4'd1: seg_o = SEG_1;
      4'd2: seg_o = SEG_2;
      4'd3: seg_o = SEG_3;
      4'd4: seg_o = SEG_4;
      4'd5: seg_o = SEG_5;
      4'd6: seg_o = SEG_6;
      4'd7: seg_o = SEG_7;
      4'd8: seg_o = SEG_8;
      4'd9: seg_o = SEG_9;
      default: seg_o = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seg_scan_driver.sv
// rtl/seg_scan_driver.sv - 4-digit multiplexed 7-segment scanner with guard band, blanking and colon blink
module seg_scan_driver
  import seg_scan_driver_pkg::*;
#(
  parameter int CLK_HZ       = DEF_CLK_HZ,
  parameter int SCAN_DIV     = DEF_SCAN_DIV,
  parameter int GUARD        = DEF_GUARD,
  parameter int COMMON_ANODE = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] acc1,
  input  logic [3:0] acc2,
  input  logic [3:0] acc3,
  input  logic [3:0] acc4,
  input  logic       blank_lz,
  input  logic       blink_en,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  localparam int HALF = (CLK_HZ / 2 > 1) ? CLK_HZ / 2 : 1;
  localparam int DW   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int BW   = (HALF > 1) ? $clog2(HALF) : 1;
  localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
  localparam logic [DW-1:0] GUARD_END  = DW'(GUARD);
  localparam logic [BW-1:0] BLINK_LAST = BW'(HALF - 1);
  localparam logic          POL        = (COMMON_ANODE != 0);

  logic [DW-1:0] dwell_q, dwell_d;
  logic [1:0]    idx_q, idx_d;
  logic [BW-1:0] blink_cnt_q, blink_cnt_d;
  logic          phase_q, phase_d;
  shadow_t       shadow_q, shadow_d;
  logic [3:0]    an_q;
  logic [6:0]    seg_q;
  logic          dp_q;

  logic          dwell_end;
  logic          anode_on;
  logic [3:0]    blank;
  logic [3:0]    cur_digit;
  logic [6:0]    seg_dec;
  logic [3:0]    an_hi;
  logic [6:0]    seg_hi;
  logic          dp_hi;

  always_comb begin
    dwell_end   = (dwell_q == DWELL_LAST);
    dwell_d     = dwell_end ? '0 : dwell_q + 1'b1;
    idx_d       = dwell_end ? idx_q + 2'd1 : idx_q;
    blink_cnt_d = (blink_cnt_q == BLINK_LAST) ? '0 : blink_cnt_q + 1'b1;
    phase_d     = (blink_cnt_q == BLINK_LAST) ? ~phase_q : phase_q;

    // Inputs are sampled only as a frame ends so a whole frame shows one coherent value.
    shadow_d = shadow_q;
    if (dwell_end && idx_q == 2'd3) begin
      shadow_d.digit    = {acc4, acc3, acc2, acc1};
      shadow_d.blank_lz = blank_lz;
      shadow_d.blink_en = blink_en;
    end
  end

  always_comb begin
    blank[3]  = shadow_q.blank_lz && (shadow_q.digit[3] == 4'd0);
    blank[2]  = blank[3] && (shadow_q.digit[2] == 4'd0);
    blank[1]  = blank[2] && (shadow_q.digit[1] == 4'd0);
    blank[0]  = 1'b0;
    cur_digit = shadow_q.digit[idx_q];
  end

  bcd_to_seg7 u_dec (
    .bcd_i (cur_digit),
    .seg_o (seg_dec)
  );

  always_comb begin
    anode_on = (dwell_q >= GUARD_END);
    an_hi    = anode_on ? (4'b0001 << idx_q) : 4'b0000;
    seg_hi   = blank[idx_q] ? SEG_BLANK : seg_dec;
    dp_hi    = anode_on && (idx_q == 2'd2) && !blank[2] && (shadow_q.blink_en ? phase_q : 1'b1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dwell_q     <= '0;
      idx_q       <= '0;
      blink_cnt_q <= '0;
      phase_q     <= 1'b0;
      shadow_q    <= '0;
      an_q        <= {4{POL}};
      seg_q       <= {7{POL}};
      dp_q        <= POL;
    end else begin
      dwell_q     <= dwell_d;
      idx_q       <= idx_d;
      blink_cnt_q <= blink_cnt_d;
      phase_q     <= phase_d;
      shadow_q    <= shadow_d;
      an_q        <= an_hi ^ {4{POL}};
      seg_q       <= seg_hi ^ {7{POL}};
      dp_q        <= dp_hi ^ POL;
    end
  end

  assign an  = an_q;
  assign seg = seg_q;
  assign dp  = dp_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// tb/tb_seg_scan_driver.sv - randomized self-checking bench for seg_scan_driver
module tb_seg_scan_driver;

  localparam int CLK_HZ   = 32;
  localparam int SCAN_DIV = 8;
  localparam int GUARD    = 2;
  localparam int FRAME    = 4 * SCAN_DIV;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] acc1, acc2, acc3, acc4;
  logic       blank_lz, blink_en;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;

  int n_checks = 0;
  int n_errors = 0;

  int   k;
  int   sh_d[4];
  bit   sh_blz, sh_blk;
  logic [6:0] segtab[10];

  seg_scan_driver #(
    .CLK_HZ(CLK_HZ), .SCAN_DIV(SCAN_DIV), .GUARD(GUARD), .COMMON_ANODE(1)
  ) dut (
    .clk(clk), .rst(rst),
    .acc1(acc1), .acc2(acc2), .acc3(acc3), .acc4(acc4),
    .blank_lz(blank_lz), .blink_en(blink_en),
    .an(an), .seg(seg), .dp(dp)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [11:0] got, input logic [11:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s at t=%0t k=%0d: got an/seg/dp=%b_%b_%b, expected %b_%b_%b",
               tag, $time, k, got[11:8], got[7:1], got[0], exp[11:8], exp[7:1], exp[0]);
    end
  endtask

  // Expected pin levels (active-low) one edge after the scanner has been running kk cycles.
  function automatic logic [11:0] model_pins(input int kk);
    int dwell, idx, phase;
    bit blank[4];
    bit lead;
    bit on;
    logic [3:0] an_h;
    logic [6:0] seg_h;
    logic       dp_h;
    dwell = kk % SCAN_DIV;
    idx   = (kk / SCAN_DIV) % 4;
    phase = (kk / (CLK_HZ / 2)) % 2;
    lead  = sh_blz;
    for (int i = 3; i >= 0; i--) begin
      blank[i] = lead && (i != 0) && (sh_d[i] == 0);
      lead     = blank[i];
    end
    on    = (dwell >= GUARD);
    an_h  = on ? 4'(1 << idx) : 4'b0000;
    seg_h = blank[idx] ? 7'h00 : ((sh_d[idx] <= 9) ? segtab[sh_d[idx]] : 7'h00);
    dp_h  = on && (idx == 2) && !blank[2] && (!sh_blk || phase == 1);
    return ~{an_h, seg_h, dp_h};
  endfunction

  task automatic model_reset();
    k = 0;
    for (int i = 0; i < 4; i++) sh_d[i] = 0;
    sh_blz = 0;
    sh_blk = 0;
  endtask

  task automatic step(input string tag);
    logic [11:0] exp;
    @(posedge clk);
    if (rst) begin
      exp = 12'hFFF;
      model_reset();
    end else begin
      exp = model_pins(k);
      if (k % FRAME == FRAME - 1) begin
        sh_d[0] = int'(acc1); sh_d[1] = int'(acc2);
        sh_d[2] = int'(acc3); sh_d[3] = int'(acc4);
        sh_blz  = blank_lz;
        sh_blk  = blink_en;
      end
      k++;
    end
    @(negedge clk);
    check_val(tag, {an, seg, dp}, exp);
  endtask

  task automatic set_digits(input logic [3:0] d4, input logic [3:0] d3,
                            input logic [3:0] d2, input logic [3:0] d1);
    acc4 = d4; acc3 = d3; acc2 = d2; acc1 = d1;
  endtask

  task automatic run_until_phase(input string tag, input int pos);
    for (int i = 0; i < FRAME && (k % FRAME) != pos; i++) step(tag);
  endtask

  function automatic logic [3:0] rand_digit();
    int r;
    r = $urandom_range(0, 15);
    if (r < 6) return 4'd0;
    if (r < 14) return 4'($urandom_range(0, 9));
    return 4'($urandom_range(10, 15));
  endfunction

  initial begin
    segtab = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
    rst = 1'b1;
    set_digits(4'd0, 4'd0, 4'd0, 4'd0);
    blank_lz = 1'b0;
    blink_en = 1'b0;
    model_reset();

    repeat (3) @(negedge clk);
    check_val("reset_pins", {an, seg, dp}, 12'hFFF);
    rst = 1'b0;

    // Minutes/seconds 60:00 without blanking
    set_digits(4'd6, 4'd0, 4'd0, 4'd0);
    repeat (3 * FRAME) step("scan_6000");

    // Leading-zero blanking of 00:45
    set_digits(4'd0, 4'd0, 4'd4, 4'd5);
    blank_lz = 1'b1;
    repeat (2 * FRAME) step("blank_0045");

    // Mid-frame input change must wait for the next frame boundary
    set_digits(4'd1, 4'd2, 4'd3, 4'd9);
    blank_lz = 1'b0;
    run_until_phase("tear_setup", 0);
    repeat (FRAME) step("tear_setup");
    run_until_phase("tear_setup", 10);
    acc1 = 4'd8;
    repeat (2 * FRAME) step("no_tearing");

    // Colon blink on, then steady
    blink_en = 1'b1;
    repeat (3 * FRAME) step("blink_on");
    blink_en = 1'b0;
    repeat (2 * FRAME) step("blink_off");

    // Non-BCD code on the rightmost digit
    set_digits(4'd5, 4'd9, 4'd2, 4'hC);
    repeat (2 * FRAME) step("non_bcd");

    // Asynchronous reset during the colon digit
    run_until_phase("pre_rst", 2 * SCAN_DIV + 4);
    rst = 1'b1;
    #1;
    check_val("async_rst", {an, seg, dp}, 12'hFFF);
    repeat (3) step("in_rst");
    rst = 1'b0;
    repeat (2 * FRAME) step("after_rst");

    // Randomized frames with occasional mid-frame changes
    for (int f = 0; f < 30; f++) begin
      set_digits(rand_digit(), rand_digit(), rand_digit(), rand_digit());
      blank_lz = 1'($urandom_range(0, 1));
      blink_en = 1'($urandom_range(0, 1));
      for (int c = 0; c < FRAME; c++) begin
        if ($urandom_range(0, 15) == 0) acc1 = rand_digit();
        if ($urandom_range(0, 31) == 0) blank_lz = ~blank_lz;
        step("random");
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
